// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, Status/Cause bit
// positions and the mtc0-writable masks.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int ST_BEV = 22;
  localparam int ST_EXL = 1;
  localparam int ST_IE  = 0;
  localparam int CA_BD  = 31;
  localparam int CA_TI  = 30;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_CONST = 32'h0040_0000;

endpackage

// File: rtl/cp0_regfile_if.sv
// Pipeline <-> CP0 bundle: mtc0/mfc0 port, exception/eret commit, and the
// per-cycle Status/Cause/Count/EPC feedback.
interface cp0_regfile_if;
  import cp0_pkg::*;

  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic        exc_badvaddr_we;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] count_o;
  logic [31:0] epc_o;
  logic        timer_int_o;

  modport master (
    output we, waddr, wdata, raddr, hw_int,
    output exc_valid, exc_code, exc_bd, exc_epc, exc_badvaddr_we, exc_badvaddr, eret,
    input  rdata, status_o, cause_o, count_o, epc_o, timer_int_o
  );

  modport slave (
    input  we, waddr, wdata, raddr, hw_int,
    input  exc_valid, exc_code, exc_bd, exc_epc, exc_badvaddr_we, exc_badvaddr, eret,
    output rdata, status_o, cause_o, count_o, epc_o, timer_int_o
  );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once per COUNT_DIV cycles, TI is a
// sticky match flag cleared only by a Compare write.
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  localparam logic DIV_LAST = (COUNT_DIV == 2);

  logic        r_div;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_tick;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div     <= 1'b0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      r_div <= w_tick ? 1'b0 : ~r_div;
      // An explicit Count load overrides the tick; the divider keeps running.
      if (i_count_we)
        r_count <= i_wdata;
      else if (w_tick)
        r_count <= r_count + 32'd1;
      if (i_compare_we)
        r_compare <= i_wdata;
      // Compare write beats a coincident match.
      if (i_compare_we)
        r_ti <= 1'b0;
      else if (r_count == r_compare)
        r_ti <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: exception/eret commit, mtc0/mfc0, interrupt sampling.
// Define CP0_TIMER_EN to build the Count/Compare timer (cp0_timer).
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int unsigned COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input logic           clk,
  input logic           resetn,
  cp0_regfile_if.slave  bus
);

  if (COUNT_DIV != 1 && COUNT_DIV != 2) begin : g_bad_div
    $error("cp0_regfile: COUNT_DIV must be 1 or 2");
  end

  logic [7:0]  r_status_im;
  logic        r_status_exl;
  logic        r_status_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip_hw;
  logic [1:0]  r_cause_ip_sw;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic        w_wr;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [31:0] w_status;
  logic [31:0] w_cause;

  // An exception commit drops a same-cycle mtc0 entirely.
  assign w_wr = bus.we & ~bus.exc_valid;

`ifdef CP0_TIMER_EN
  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .i_count_we   (w_wr && (bus.waddr == CP0_COUNT)),
    .i_compare_we (w_wr && (bus.waddr == CP0_COMPARE)),
    .i_wdata      (bus.wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );
`else
  assign w_count   = '0;
  assign w_compare = '0;
  assign w_ti      = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_status_im   <= STATUS_RESET[15:8];
      r_status_exl  <= STATUS_RESET[ST_EXL];
      r_status_ie   <= STATUS_RESET[ST_IE];
      r_cause_bd    <= 1'b0;
      r_cause_ip_hw <= '0;
      r_cause_ip_sw <= '0;
      r_cause_exc   <= '0;
      r_epc         <= '0;
      r_badvaddr    <= '0;
    end else begin
      r_cause_ip_hw <= bus.hw_int;
      if (bus.exc_valid) begin
        r_cause_exc <= bus.exc_code;
        if (bus.exc_badvaddr_we)
          r_badvaddr <= bus.exc_badvaddr;
        // Nested exceptions keep the original EPC/BD for the outer handler.
        if (!r_status_exl) begin
          r_epc        <= bus.exc_epc;
          r_cause_bd   <= bus.exc_bd;
          r_status_exl <= 1'b1;
        end
      end else begin
        if (w_wr && bus.waddr == CP0_STATUS) begin
          r_status_im  <= bus.wdata[15:8];
          r_status_ie  <= bus.wdata[ST_IE];
          r_status_exl <= bus.eret ? 1'b0 : bus.wdata[ST_EXL];
        end else if (bus.eret) begin
          r_status_exl <= 1'b0;
        end
        if (w_wr && bus.waddr == CP0_CAUSE)
          r_cause_ip_sw <= bus.wdata[9:8];
        if (w_wr && bus.waddr == CP0_EPC)
          r_epc <= bus.wdata;
      end
    end
  end

  assign w_status = STATUS_CONST | {16'h0, r_status_im, 6'h0, r_status_exl, r_status_ie};
  assign w_cause  = {r_cause_bd, w_ti, 14'h0, r_cause_ip_hw[5] | w_ti, r_cause_ip_hw[4:0],
                     r_cause_ip_sw, 1'b0, r_cause_exc, 2'b00};

  always_comb begin
    bus.rdata = '0;
    case (bus.raddr)
      CP0_BADVADDR: bus.rdata = r_badvaddr;
      CP0_COUNT:    bus.rdata = w_count;
      CP0_COMPARE:  bus.rdata = w_compare;
      CP0_STATUS:   bus.rdata = w_status;
      CP0_CAUSE:    bus.rdata = w_cause;
      CP0_EPC:      bus.rdata = r_epc;
      default:      bus.rdata = '0;
    endcase
  end

  assign bus.status_o    = w_status;
  assign bus.cause_o     = w_cause;
  assign bus.count_o     = w_count;
  assign bus.epc_o       = r_epc;
  assign bus.timer_int_o = w_ti;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile; expected values are queued by the driver
// and compared by a negedge monitor.
module tb_cp0_regfile;
  import cp0_pkg::*;

  localparam int S_RD    = 0;
  localparam int S_STAT  = 1;
  localparam int S_CAUSE = 2;
  localparam int S_COUNT = 3;
  localparam int S_EPC   = 4;
  localparam int S_TI    = 5;
  localparam int S_CTMR  = 6;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cp0_regfile_if bus ();

  cp0_regfile #(.COUNT_DIV(2), .STATUS_RESET(32'h0040_0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_RD:    return bus.rdata;
      S_STAT:  return bus.status_o;
      S_CAUSE: return bus.cause_o;
      S_COUNT: return bus.count_o;
      S_EPC:   return bus.epc_o;
      S_TI:    return {31'h0, bus.timer_int_o};
      default: return bus.cause_o & 32'hC000_8000;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      automatic int          s = sel_q.pop_front();
      automatic logic [31:0] e = exp_q.pop_front();
      automatic string       n = name_q.pop_front();
      automatic logic [31:0] a = observe(s);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got %08h expected %08h", n, a, e);
      end
    end
  end

  task automatic expect_out(input int sel, input logic [31:0] e, input string n);
    sel_q.push_back(sel);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
    bus.hw_int = '0; bus.exc_valid = 1'b0; bus.exc_code = '0; bus.exc_bd = 1'b0;
    bus.exc_epc = '0; bus.exc_badvaddr_we = 1'b0; bus.exc_badvaddr = '0; bus.eret = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    tick();
    bus.we = 1'b0;
  endtask

  // Reads the register during its own write cycle: must still see the old value.
  task automatic mtc0_chk_old(input logic [4:0] a, input logic [31:0] d,
                              input logic [31:0] old, input string n);
    bus.raddr = a;
    expect_out(S_RD, old, n);
    mtc0(a, d);
  endtask

  task automatic check_rd(input logic [4:0] a, input logic [31:0] e, input string n);
    bus.raddr = a;
    expect_out(S_RD, e, n);
    tick();
  endtask

  task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] epc,
                     input logic bv_we, input logic [31:0] bv, input logic with_eret);
    bus.exc_valid = 1'b1; bus.exc_code = code; bus.exc_bd = bd; bus.exc_epc = epc;
    bus.exc_badvaddr_we = bv_we; bus.exc_badvaddr = bv; bus.eret = with_eret;
    tick();
    bus.exc_valid = 1'b0; bus.exc_badvaddr_we = 1'b0; bus.eret = 1'b0;
  endtask

  task automatic do_eret();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    tick(); tick();
    check_rd(CP0_STATUS, 32'h0040_0000, "rst_status");
    check_rd(CP0_CAUSE, 32'h0, "rst_cause");
    check_rd(CP0_EPC, 32'h0, "rst_epc");
    check_rd(CP0_COUNT, 32'h0, "rst_count");
    check_rd(CP0_BADVADDR, 32'h0, "rst_badvaddr");
    resetn = 1'b1;
    tick(); tick();
`ifdef CP0_TIMER_EN
    expect_out(S_COUNT, 32'd1, "count_after_2");
`else
    expect_out(S_COUNT, 32'd0, "count_absent");
`endif
    tick();
    // Park Compare far away so the reset-time match does not linger.
    mtc0(CP0_COMPARE, 32'hFFFF_FFFF);
    expect_out(S_TI, 32'h0, "ti_idle");
    check_rd(CP0_CAUSE, 32'h0, "cause_idle");

    mtc0_chk_old(CP0_STATUS, 32'hFFFF_FFFF, 32'h0040_0000, "status_no_bypass");
    check_rd(CP0_STATUS, 32'h0040_FF03, "status_wmask");
    mtc0(CP0_STATUS, 32'h0);
    check_rd(CP0_STATUS, 32'h0040_0000, "status_cleared");
    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    check_rd(CP0_CAUSE, 32'h0000_0300, "cause_wmask");
    mtc0(CP0_CAUSE, 32'h0);

    bus.hw_int = 6'b100101;
    tick();
    expect_out(S_CAUSE, 32'h0000_9400, "cause_hw_int");
    tick();
    bus.hw_int = 6'b000000;
    tick();
    expect_out(S_CAUSE, 32'h0, "cause_hw_int_clr");
    tick();

    mtc0(5'd5, 32'hFFFF_FFFF);
    check_rd(5'd5, 32'h0, "unmapped_read");
    mtc0(CP0_BADVADDR, 32'h0000_DEAD);
    check_rd(CP0_BADVADDR, 32'h0, "badvaddr_ro");

    exc(EXC_ADEL, 1'b1, 32'hBFC0_0100, 1'b1, 32'h0000_1235, 1'b0);
    bus.raddr = CP0_BADVADDR;
    expect_out(S_STAT, 32'h0040_0002, "exc1_status");
    expect_out(S_CAUSE, 32'h8000_0010, "exc1_cause");
    expect_out(S_EPC, 32'hBFC0_0100, "exc1_epc");
    expect_out(S_RD, 32'h0000_1235, "exc1_badvaddr");
    tick();

    exc(EXC_OV, 1'b0, 32'h0000_0040, 1'b0, 32'h0, 1'b0);
    expect_out(S_CAUSE, 32'h8000_0030, "exc2_cause");
    expect_out(S_EPC, 32'hBFC0_0100, "exc2_epc_kept");
    expect_out(S_STAT, 32'h0040_0002, "exc2_status");
    expect_out(S_RD, 32'h0000_1235, "exc2_badvaddr_kept");
    tick();

    do_eret();
    expect_out(S_STAT, 32'h0040_0000, "eret_status");
    expect_out(S_EPC, 32'hBFC0_0100, "eret_epc");
    tick();

    exc(EXC_SYS, 1'b0, 32'h0000_0300, 1'b0, 32'h0, 1'b1);
    expect_out(S_STAT, 32'h0040_0002, "exc_eret_status");
    expect_out(S_EPC, 32'h0000_0300, "exc_eret_epc");
    expect_out(S_CAUSE, 32'h0000_0020, "exc_eret_cause");
    tick();
    do_eret();
    expect_out(S_STAT, 32'h0040_0000, "eret2_status");
    tick();

    bus.eret = 1'b1;
    mtc0(CP0_STATUS, 32'hFFFF_FF03);
    bus.eret = 1'b0;
    expect_out(S_STAT, 32'h0040_FF01, "eret_with_mtc0");
    tick();
    mtc0(CP0_STATUS, 32'h0);

    bus.we = 1'b1; bus.waddr = CP0_EPC; bus.wdata = 32'h0000_0100;
    exc(EXC_RI, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 1'b0);
    bus.we = 1'b0;
    expect_out(S_EPC, 32'h0000_0200, "exc_drops_mtc0");
    expect_out(S_STAT, 32'h0040_0002, "exc3_status");
    expect_out(S_CAUSE, 32'h8000_0028, "exc3_cause");
    tick();
    do_eret();
    mtc0(CP0_EPC, 32'h1234_5678);
    expect_out(S_EPC, 32'h1234_5678, "epc_out");
    check_rd(CP0_EPC, 32'h1234_5678, "epc_write");

`ifdef CP0_TIMER_EN
    mtc0(CP0_COMPARE, 32'd5);
    mtc0(CP0_COUNT, 32'd3);
    for (int i = 0; i < 20 && bus.count_o != 32'd5; i++) tick();
    expect_out(S_COUNT, 32'd5, "count_reached_5");
    expect_out(S_TI, 32'h0, "ti_not_yet");
    tick();
    expect_out(S_TI, 32'h1, "ti_set");
    expect_out(S_CTMR, 32'hC000_8000, "cause_ti_ip7");
    tick();
    mtc0_chk_old(CP0_COMPARE, 32'hFFFF_FFFF, 32'd5, "compare_rd");
    expect_out(S_TI, 32'h0, "ti_cleared");
    tick();
    mtc0(CP0_COMPARE, 32'h50);
    mtc0(CP0_COUNT, 32'h50);
    mtc0(CP0_COMPARE, 32'h60);
    expect_out(S_TI, 32'h0, "clear_beats_match");
    tick();
    expect_out(S_TI, 32'h0, "clear_beats_match_hold");
    tick();
`else
    mtc0(CP0_COUNT, 32'd77);
    mtc0(CP0_COMPARE, 32'd3);
    check_rd(CP0_COUNT, 32'h0, "count_absent_rd");
    check_rd(CP0_COMPARE, 32'h0, "compare_absent_rd");
    expect_out(S_COUNT, 32'h0, "count_absent_out");
    expect_out(S_TI, 32'h0, "ti_absent");
    tick();
`endif

    tick(); tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
